// File: rtl/audio_source_sequencer.sv
// ============================================================================
// Module      : audio_source_sequencer
// Description : Debounces board switches and commits them to the audio selector
//               behind a gain fade-out / fade-in so source changes never click.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_source_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int GAIN_W          = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        switches,
    input  logic signed [15:0] pcm_in,
    input  logic               pcm_in_valid,
    output logic [15:0]        sel_switches,
    output logic signed [15:0] pcm_out,
    output logic               pcm_out_valid,
    output logic               busy
);

    localparam int c_CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_PROD_W = 17 + GAIN_W;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAIN_W:0]    c_GAIN_FULL = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0]    c_GAIN_ONE  = {{GAIN_W{1'b0}}, 1'b1};
    localparam logic [GAIN_W:0]    c_GAIN_ZERO = '0;
    localparam logic [GAIN_W:0]    c_GAIN_LAST = c_GAIN_FULL - c_GAIN_ONE;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_FADE_OUT = 2'd1;
    localparam logic [1:0] c_SWITCH   = 2'd2;
    localparam logic [1:0] c_FADE_IN  = 2'd3;

    logic [15:0]        r_sync1;
    logic [15:0]        r_sync2;
    logic [15:0]        r_cand;
    logic [15:0]        r_stable;
    logic [c_CNT_W-1:0] r_cnt;
    logic [15:0]        r_sel;
    logic [1:0]         r_state;
    logic [GAIN_W:0]    r_gain;
    logic signed [15:0] r_pcm_out;
    logic               r_pcm_out_valid;

    logic [1:0]            w_state_nx;
    logic [GAIN_W:0]       w_gain_nx;
    logic                  w_pending;
    logic                  w_commit;
    logic                  w_busy;
    logic signed [c_PROD_W-1:0] w_pcm_ext;
    logic signed [c_PROD_W-1:0] w_gain_ext;
    logic signed [c_PROD_W-1:0] w_prod;
    logic                  w_unused_prod_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= switches;
            r_sync2 <= r_sync1;
        end
    end

    // r_cand remembers last cycle's synchronized value so any change restarts the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else begin
            r_cand <= r_sync2;
            if (r_sync2 != r_cand) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_pending = (r_stable != r_sel);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_FADE_IN;
            r_gain  <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_gain  <= w_gain_nx;
            if (w_commit) begin
                r_sel <= r_stable;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_gain_nx  = r_gain;
        case (r_state)
            c_IDLE: begin
                w_gain_nx = c_GAIN_FULL;
                if (w_pending) begin
                    w_state_nx = c_FADE_OUT;
                end
            end
            c_FADE_OUT: begin
                // A reversal from FADE_IN at zero gain has nothing left to ramp
                if (r_gain == c_GAIN_ZERO) begin
                    w_state_nx = c_SWITCH;
                end else if (pcm_in_valid) begin
                    w_gain_nx = r_gain - c_GAIN_ONE;
                    if (r_gain == c_GAIN_ONE) begin
                        w_state_nx = c_SWITCH;
                    end
                end
            end
            c_SWITCH: begin
                w_state_nx = c_FADE_IN;
            end
            c_FADE_IN: begin
                // Finishing the ramp wins over a pending change; IDLE picks it up next cycle
                if (r_gain == c_GAIN_FULL) begin
                    w_state_nx = c_IDLE;
                end else if (pcm_in_valid && (r_gain == c_GAIN_LAST)) begin
                    w_gain_nx  = c_GAIN_FULL;
                    w_state_nx = c_IDLE;
                end else if (w_pending) begin
                    w_state_nx = c_FADE_OUT;
                end else if (pcm_in_valid) begin
                    w_gain_nx = r_gain + c_GAIN_ONE;
                end
            end
            default: begin
                w_state_nx = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_busy   = (r_state != c_IDLE);
        w_commit = (r_state == c_SWITCH);
    end

    assign w_pcm_ext  = {{(GAIN_W + 1){pcm_in[15]}}, pcm_in};
    assign w_gain_ext = {16'b0, r_gain};
    assign w_prod     = w_pcm_ext * w_gain_ext;

    // Slicing at GAIN_W is the arithmetic right shift (floor) of the product
    assign w_unused_prod_bits = ^{w_prod[c_PROD_W-1], w_prod[GAIN_W-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pcm_out       <= '0;
            r_pcm_out_valid <= 1'b0;
        end else begin
            r_pcm_out_valid <= pcm_in_valid;
            if (pcm_in_valid) begin
                r_pcm_out <= w_prod[GAIN_W+15:GAIN_W];
            end
        end
    end

    assign sel_switches  = r_sel;
    assign pcm_out       = r_pcm_out;
    assign pcm_out_valid = r_pcm_out_valid;
    assign busy          = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_audio_source_sequencer.sv
// ============================================================================
// Module      : tb_audio_source_sequencer
// Description : Directed scoreboard bench for audio_source_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_source_sequencer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [15:0]        switches;
    logic signed [15:0] pcm_in;
    logic               pcm_in_valid;
    logic [15:0]        sel_switches;
    logic signed [15:0] pcm_out;
    logic               pcm_out_valid;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic signed [15:0] exp_q[$];

    always #5 clk = ~clk;

    audio_source_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .GAIN_W         (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .switches     (switches),
        .pcm_in       (pcm_in),
        .pcm_in_valid (pcm_in_valid),
        .sel_switches (sel_switches),
        .pcm_out      (pcm_out),
        .pcm_out_valid(pcm_out_valid),
        .busy         (busy)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every output sample is matched against the oldest expectation
    always @(negedge clk) begin : monitor
        logic signed [15:0] e;
        if (pcm_out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pcm_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("pcm_out", int'(pcm_out), int'(e));
            end
        end
    end

    task automatic sample(input logic signed [15:0] d, input logic signed [15:0] e);
        @(negedge clk);
        pcm_in       = d;
        pcm_in_valid = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pcm_in_valid = 1'b0;
        end
    endtask

    task automatic wait_busy(input string name);
        int found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pcm_in_valid = 1'b0;
            if (busy) begin
                found = 1;
                break;
            end
        end
        check(name, found, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        switches     = 16'h0000;
        pcm_in       = '0;
        pcm_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sel_switches", int'(sel_switches), 0);
        check("reset_pcm_out", int'(pcm_out), 0);
        check("reset_pcm_out_valid", int'(pcm_out_valid), 0);
        check("reset_busy", int'(busy), 1);
        rst_n = 1'b1;

        // Power-up fade-in from zero gain
        sample(16'sd1000, 16'sd0);
        sample(16'sd1000, 16'sd250);
        sample(16'sd1000, 16'sd500);
        sample(16'sd1000, 16'sd750);
        idle(1);
        check("busy_after_fade_in", int'(busy), 0);
        sample(16'sd1000, 16'sd1000);
        sample(-16'sd32768, -16'sd32768);
        idle(1);

        // Glitch shorter than the debounce window is ignored
        @(negedge clk);
        switches = 16'h0004;
        repeat (3) @(negedge clk);
        switches = 16'h0000;
        idle(12);
        check("glitch_busy", int'(busy), 0);
        check("glitch_sel_switches", int'(sel_switches), 0);

        // Full source change sequence
        @(negedge clk);
        switches = 16'h0004;
        wait_busy("change1_fade_out_start");
        sample(16'sd1000, 16'sd1000);
        sample(16'sd1000, 16'sd750);
        sample(16'sd1000, 16'sd500);
        sample(16'sd1000, 16'sd250);
        sample(16'sd1000, 16'sd0);
        sample(16'sd1000, 16'sd0);
        sample(16'sd1000, 16'sd250);
        sample(16'sd1000, 16'sd500);
        sample(16'sd1000, 16'sd750);
        sample(16'sd1000, 16'sd1000);
        idle(1);
        check("change1_sel_switches", int'(sel_switches), 4);
        check("change1_busy", int'(busy), 0);

        // Fade-out frozen without samples, negative rounding, partial fade-in
        @(negedge clk);
        switches = 16'h0000;
        wait_busy("change2_fade_out_start");
        sample(16'sd1000, 16'sd1000);
        sample(16'sd1000, 16'sd750);
        idle(20);
        check("freeze_busy", int'(busy), 1);
        check("freeze_sel_switches", int'(sel_switches), 4);
        check("freeze_pcm_out_hold", int'(pcm_out), 750);
        check("freeze_pcm_out_valid", int'(pcm_out_valid), 0);
        sample(-16'sd1, -16'sd1);
        sample(16'sd1000, 16'sd250);
        sample(16'sd1000, 16'sd0);
        sample(16'sd1000, 16'sd0);
        sample(16'sd1000, 16'sd250);
        idle(1);
        check("change2_sel_switches", int'(sel_switches), 0);
        check("change2_busy_mid_fade_in", int'(busy), 1);

        // New change during fade-in at gain 2 reverses without a jump
        @(negedge clk);
        switches = 16'h0008;
        idle(15);
        check("reverse_busy", int'(busy), 1);
        check("reverse_sel_before_commit", int'(sel_switches), 0);
        sample(16'sd1000, 16'sd500);
        sample(16'sd1000, 16'sd250);
        sample(16'sd1000, 16'sd0);
        sample(16'sd1000, 16'sd0);
        sample(16'sd1000, 16'sd250);
        sample(16'sd1000, 16'sd500);
        sample(16'sd1000, 16'sd750);
        sample(16'sd1000, 16'sd1000);
        idle(1);
        check("reverse_sel_switches", int'(sel_switches), 8);
        check("reverse_busy_done", int'(busy), 0);

        // Reset mid-ramp abandons the change
        @(negedge clk);
        switches = 16'h0010;
        wait_busy("change3_fade_out_start");
        sample(16'sd1000, 16'sd1000);
        @(negedge clk);
        pcm_in_valid = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_sel_switches", int'(sel_switches), 0);
        check("midreset_busy", int'(busy), 1);
        check("midreset_pcm_out", int'(pcm_out), 0);
        check("midreset_pcm_out_valid", int'(pcm_out_valid), 0);
        rst_n = 1'b1;
        idle(2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
